rv32i_mem_arbiter: RTL and testbench
====================================

Name: rv32i_mem_arbiter

Overview:
- Shares one single-port synchronous SRAM between the core's instruction-fetch port (I) and data port (D).
- Grants one access per cycle, using fixed D-over-I priority with an aging counter so fetch is never starved.
- Returns read data one cycle after grant.
- Sits between rv32i_cpu-class cores (with stall on !ready) and the unified program/data memory.

Parameters:
- ADDR_W, 12, word-address width of the SRAM (depth = 2**ADDR_W words).
- MAX_WAIT, 4, consecutive denied cycles after which a pending I request overrides D priority (legal range 1..15).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- i_req  in  1  fetch request valid
- i_addr  in  32  fetch byte address
- i_ready  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch read data valid
- i_rdata  out  32  fetch read data
- d_req  in  1  data request valid
- d_addr  in  32  data byte address
- d_we  in  4  byte write enables; 0 = read
- d_wdata  in  32  store data, already lane-aligned
- d_ready  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  32  load data, raw word
- mem_en  out  1  SRAM access enable
- mem_we  out  4  SRAM byte write enables
- mem_addr  out  ADDR_W  SRAM word address
- mem_wdata  out  32  SRAM write data
- mem_rdata  in  32  SRAM read data, valid the cycle after mem_en with mem_we==0

Behaviour:
- Clocking and reset:
  - Single clock domain; reset is synchronous and active-high on clk/rst.
  - Reset values: every registered output, aging counter, response-owner register and grant state = 0.
  - rst mid-operation drops any pending read response; no rvalid in the cycle after rst is sampled high.
- Grant logic (combinational from current requests and registered state):
  - force_i = i_req && (wait_cnt >= MAX_WAIT).
  - Grant D if d_req && !force_i; else grant I if i_req; else none.
  - i_ready = I granted; d_ready = D granted. At most one ready high per cycle.
  - Requester must hold req/addr/wdata stable until ready.
- Memory drive:
  - mem_en = any grant.
  - mem_addr = granted addr[ADDR_W+1:2]; addr[1:0] ignored; bits above ADDR_W+1 ignored (wrap).
  - mem_we = d_we when D granted, else 0.
  - mem_wdata = d_wdata.
  - When idle: mem_we = 0, mem_addr holds last value.
- Response pipeline (states IDLE / RD_I / RD_D, one registered field):
  - Next state = RD_I if I granted; RD_D if D granted with d_we==0; else IDLE.
  - In RD_I: i_rvalid = 1, i_rdata = mem_rdata. In RD_D: d_rvalid = 1, d_rdata = mem_rdata.
  - rvalid is a 1-cycle pulse; rdata outputs = 0 when the corresponding rvalid = 0.
  - Back-to-back grants are fully pipelined: a new grant may be issued in the same cycle a prior response is returned.
- Writes: complete on acceptance; no rvalid generated.
- Aging counter wait_cnt (4 bits):
  - Increments when i_req && !i_ready; saturates at 15.
  - Clears when i_ready, or when !i_req.
- Simultaneous i_req && d_req:
  - D wins until wait_cnt reaches MAX_WAIT, then I wins once and the counter clears.
  - D is stalled for exactly that cycle.
- Latency: grant same cycle as req (0 wait when uncontended); read data at grant+1.

Optional Feature:
- Macro RV32I_ARB_PERF_EN.
- When defined: adds outputs perf_i_stall (32) and perf_d_stall (32).
  - Each is a free-running counter of cycles in which that port's req is high and ready is low.
  - Wraps at 2**32; reset to 0 by rst.
- When undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset: hold rst 2 cycles with i_req=d_req=1 -> i_ready=d_ready=0, mem_en=0, i_rvalid=d_rvalid=0 throughout, wait_cnt=0 after.
- Single fetch: preload word 3 = 0x00000013; i_req with i_addr=0x0C -> i_ready same cycle, mem_addr=3, next cycle i_rvalid=1, i_rdata=0x00000013.
- Store then load: d_req d_we=4'b0010 d_addr=0x40 d_wdata=0x0000AB00 over 0x11223344 -> next-cycle load at 0x40 returns d_rvalid=1, d_rdata=0x1122AB44; no rvalid after the store.
- Contention aging, MAX_WAIT=4: i_req and d_req held high 8 cycles -> grant sequence D,D,D,D,I,D,D,D. The I grant in cycle 5 is followed by i_rvalid in cycle 6.
- Reset mid-read: grant I read in cycle N, assert rst in cycle N+1 -> i_rvalid=0 in N+1 and N+2.
- Address wrap, ADDR_W=12: d_addr=0x00004008 read -> mem_addr=2, same data as d_addr=0x8.

Source files
------------

// File: rtl/rv32i_mem_arbiter.sv
// Arbitrates one single-port SRAM between the fetch (I) and data (D) ports of an rv32i core.
// Optional stall counters are compiled in with RV32I_ARB_PERF_EN.
module rv32i_mem_arbiter #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_ready,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic [31:0]       d_addr,
  input  logic [3:0]        d_we,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
`ifdef RV32I_ARB_PERF_EN
  ,
  output logic [31:0]       perf_i_stall,
  output logic [31:0]       perf_d_stall
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_I = 2'd1,
    RD_D = 2'd2
  } rsp_state_e;

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  rsp_state_e        state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              force_i;
  logic              grant_i;
  logic              grant_d;

  // Byte-offset bits and bits above the SRAM depth are ignored (address wraps).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                              d_addr[31:ADDR_W+2], d_addr[1:0]};

  always_comb begin
    force_i = i_req && (wait_cnt_q >= MaxWait);
    grant_d = !rst && d_req && !force_i;
    grant_i = !rst && i_req && !grant_d;
  end

  always_comb begin
    addr_d = addr_q;
    if (grant_d) begin
      addr_d = d_addr[ADDR_W+1:2];
    end else if (grant_i) begin
      addr_d = i_addr[ADDR_W+1:2];
    end
  end

  assign i_ready   = grant_i;
  assign d_ready   = grant_d;
  assign mem_en    = grant_i || grant_d;
  assign mem_we    = grant_d ? d_we : '0;
  assign mem_addr  = addr_d;
  assign mem_wdata = d_wdata;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!i_req || grant_i) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != 4'hF) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      addr_q     <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
    end
  end

  // Response FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Response FSM: next state
  always_comb begin
    state_d = IDLE;
    if (grant_i) begin
      state_d = RD_I;
    end else if (grant_d && (d_we == 4'd0)) begin
      state_d = RD_D;
    end
  end

  // Response FSM: outputs. Gating with rst kills a response already in flight
  // in the same cycle the reset is sampled.
  always_comb begin
    i_rvalid = 1'b0;
    i_rdata  = '0;
    d_rvalid = 1'b0;
    d_rdata  = '0;
    if (!rst) begin
      case (state_q)
        RD_I: begin
          i_rvalid = 1'b1;
          i_rdata  = mem_rdata;
        end
        RD_D: begin
          d_rvalid = 1'b1;
          d_rdata  = mem_rdata;
        end
        default: ;
      endcase
    end
  end

`ifdef RV32I_ARB_PERF_EN
  logic [31:0] perf_i_stall_q;
  logic [31:0] perf_d_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_i_stall_q <= '0;
      perf_d_stall_q <= '0;
    end else begin
      if (i_req && !grant_i) perf_i_stall_q <= perf_i_stall_q + 32'd1;
      if (d_req && !grant_d) perf_d_stall_q <= perf_d_stall_q + 32'd1;
    end
  end

  assign perf_i_stall = perf_i_stall_q;
  assign perf_d_stall = perf_d_stall_q;
`endif

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter with a behavioural SRAM and a read-response scoreboard.
module tb_rv32i_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [31:0] d_addr;
  logic [3:0]  d_we;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int unsigned n_cmp;
  int unsigned n_err;

  logic [31:0] i_q[$];
  logic [31:0] d_q[$];
  logic [31:0] sram [0:4095];

  rv32i_mem_arbiter #(
    .ADDR_W  (12),
    .MAX_WAIT(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_ready  (i_ready),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_addr   (d_addr),
    .d_we     (d_we),
    .d_wdata  (d_wdata),
    .d_ready  (d_ready),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model; the preload is reapplied whenever reset is held.
  always @(posedge clk) begin
    if (rst) begin
      sram[2]  <= 32'hCAFE0002;
      sram[3]  <= 32'h00000013;
      sram[16] <= 32'h11223344;
      sram[32] <= 32'hD00D0020;
      sram[48] <= 32'h1A5F0030;
    end else if (mem_en) begin
      if (mem_we == 4'd0) begin
        mem_rdata <= sram[mem_addr];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: check responses due now, check grant outputs, record expected reads.
  task automatic step(input string tag, input logic exp_ir, input logic exp_dr,
                      input logic chk_addr, input logic [11:0] exp_maddr,
                      input logic [31:0] exp_rd);
    logic [31:0] e;
    @(negedge clk);
    if (i_q.size() != 0) begin
      e = i_q.pop_front();
      chk({tag, "/i_rvalid"}, 32'(i_rvalid), 32'd1);
      chk({tag, "/i_rdata"}, i_rdata, e);
    end else begin
      chk({tag, "/i_rvalid"}, 32'(i_rvalid), 32'd0);
      chk({tag, "/i_rdata"}, i_rdata, 32'd0);
    end
    if (d_q.size() != 0) begin
      e = d_q.pop_front();
      chk({tag, "/d_rvalid"}, 32'(d_rvalid), 32'd1);
      chk({tag, "/d_rdata"}, d_rdata, e);
    end else begin
      chk({tag, "/d_rvalid"}, 32'(d_rvalid), 32'd0);
      chk({tag, "/d_rdata"}, d_rdata, 32'd0);
    end
    chk({tag, "/i_ready"}, 32'(i_ready), 32'(exp_ir));
    chk({tag, "/d_ready"}, 32'(d_ready), 32'(exp_dr));
    chk({tag, "/mem_en"}, 32'(mem_en), 32'(exp_ir | exp_dr));
    chk({tag, "/mem_we"}, 32'(mem_we), exp_dr ? 32'(d_we) : 32'd0);
    if (chk_addr) chk({tag, "/mem_addr"}, 32'(mem_addr), 32'(exp_maddr));
    if (exp_ir) i_q.push_back(exp_rd);
    if (exp_dr && d_we == 4'd0) d_q.push_back(exp_rd);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b1;
    i_req   = 1'b1;
    i_addr  = 32'h0;
    d_req   = 1'b1;
    d_addr  = 32'h0;
    d_we    = 4'd0;
    d_wdata = 32'h0;
    @(posedge clk);
    #1;

    step("rst0", 1'b0, 1'b0, 1'b0, 12'd0, 32'd0);
    step("rst1", 1'b0, 1'b0, 1'b0, 12'd0, 32'd0);
    rst   = 1'b0;
    i_req = 1'b0;
    d_req = 1'b0;
    chk("rst/wait_cnt", 32'(dut.wait_cnt_q), 32'd0);
    step("idle", 1'b0, 1'b0, 1'b1, 12'd0, 32'd0);

    i_req  = 1'b1;
    i_addr = 32'h0000000C;
    step("fetch", 1'b1, 1'b0, 1'b1, 12'd3, 32'h00000013);
    i_req = 1'b0;
    step("fetch_rsp", 1'b0, 1'b0, 1'b1, 12'd3, 32'd0);

    d_req   = 1'b1;
    d_addr  = 32'h00000040;
    d_we    = 4'b0010;
    d_wdata = 32'h0000AB00;
    step("store", 1'b0, 1'b1, 1'b1, 12'd16, 32'd0);
    d_we = 4'd0;
    step("load", 1'b0, 1'b1, 1'b1, 12'd16, 32'h1122AB44);
    d_req = 1'b0;
    step("load_rsp", 1'b0, 1'b0, 1'b1, 12'd16, 32'd0);

    i_req  = 1'b1;
    i_addr = 32'h000000C0;
    d_req  = 1'b1;
    d_addr = 32'h00000080;
    step("cont1", 1'b0, 1'b1, 1'b1, 12'd32, 32'hD00D0020);
    step("cont2", 1'b0, 1'b1, 1'b1, 12'd32, 32'hD00D0020);
    step("cont3", 1'b0, 1'b1, 1'b1, 12'd32, 32'hD00D0020);
    step("cont4", 1'b0, 1'b1, 1'b1, 12'd32, 32'hD00D0020);
    chk("cont4/wait_cnt", 32'(dut.wait_cnt_q), 32'd4);
    step("cont5", 1'b1, 1'b0, 1'b1, 12'd48, 32'h1A5F0030);
    step("cont6", 1'b0, 1'b1, 1'b1, 12'd32, 32'hD00D0020);
    step("cont7", 1'b0, 1'b1, 1'b1, 12'd32, 32'hD00D0020);
    step("cont8", 1'b0, 1'b1, 1'b1, 12'd32, 32'hD00D0020);
    i_req = 1'b0;
    d_req = 1'b0;
    step("cont_end", 1'b0, 1'b0, 1'b1, 12'd32, 32'd0);

    d_req  = 1'b1;
    d_addr = 32'h00004008;
    step("wrap", 1'b0, 1'b1, 1'b1, 12'd2, 32'hCAFE0002);
    d_addr = 32'h00000008;
    step("nowrap", 1'b0, 1'b1, 1'b1, 12'd2, 32'hCAFE0002);
    d_req = 1'b0;
    step("wrap_end", 1'b0, 1'b0, 1'b1, 12'd2, 32'd0);

    i_req  = 1'b1;
    i_addr = 32'h0000000C;
    step("rr_grant", 1'b1, 1'b0, 1'b1, 12'd3, 32'h00000013);
    i_req = 1'b0;
    rst   = 1'b1;
    i_q.delete();
    step("rr_rst", 1'b0, 1'b0, 1'b0, 12'd0, 32'd0);
    rst = 1'b0;
    step("rr_after", 1'b0, 1'b0, 1'b1, 12'd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
